dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 (CPU MEM stage) and port 1 (program/data loader or debug).
- Sits between the requesters and the data memory. Drives the memory's write strobe, read strobe, word address and write data, and captures its combinational read data.
- Provides per-port ready/valid handshakes, round-robin fairness, bounded lock (burst) ownership, and out-of-range address rejection.

---
 rtl/dmem_arbiter_pkg.sv | 8 +
 rtl/dmem_rr_pick.sv | 12 +
 rtl/dmem_arbiter.sv | 95 +++++++++
 tb/tb_dmem_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared state encoding and word width for the data-memory arbiter
package dmem_arbiter_pkg;
  localparam int DMEM_WORD_W = 64;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t OWN0 = 2'd1;
  localparam state_t OWN1 = 2'd2;
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: two-way round-robin picker; on a tie the port that was not granted last wins
module dmem_rr_pick (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_gnt,
  output logic [1:0] pick
);
  always_comb begin
    pick[0] = req0 & (~req1 | last_gnt);
    pick[1] = req1 & (~req0 | ~last_gnt);
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between two ready/valid ports
// with round-robin fairness, bounded lock bursts and out-of-range rejection
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH    = 128,
  parameter int MAX_LOCK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [63:0] addr0,
  input  logic [63:0] addr1,
  input  logic [63:0] wdata0,
  input  logic [63:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [63:0] rdata0,
  output logic [63:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        mem_write,
  output logic        mem_read,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  state_t          state;
  logic            last_gnt;
  logic [CW-1:0]   lock_cnt;
  logic [1:0]      pick;
  logic            acc, sel_we, sel_lock, oor;
  logic [63:0]     sel_addr, sel_wdata;
  dmem_rr_pick u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .pick     (pick)
  );
  // gnt is masked by rst_n so the memory sees nothing while reset is held
  always_comb begin
    gnt0      = rst_n & (state == IDLE ? pick[0] : (state == OWN0) & req0);
    gnt1      = rst_n & (state == IDLE ? pick[1] : (state == OWN1) & req1);
    acc       = gnt0 | gnt1;
    sel_addr  = gnt1 ? addr1 : addr0;
    sel_wdata = gnt1 ? wdata1 : wdata0;
    sel_we    = gnt1 ? we1 : we0;
    sel_lock  = gnt1 ? lock1 : lock0;
    oor       = sel_addr >= DMEM_WORD_W'(DEPTH);
    mem_addr  = acc ? sel_addr : '0;
    mem_wdata = acc ? sel_wdata : '0;
    mem_write = acc & sel_we & ~oor;
    mem_read  = acc & ~sel_we & ~oor;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      lock_cnt <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      rvalid0 <= gnt0;
      rvalid1 <= gnt1;
      err0    <= gnt0 & oor;
      err1    <= gnt1 & oor;
      if (gnt0) rdata0 <= (sel_we | oor) ? '0 : mem_rdata;
      if (gnt1) rdata1 <= (sel_we | oor) ? '0 : mem_rdata;
      if (acc) last_gnt <= gnt1;
      if (state == IDLE) begin
        if (acc && sel_lock && MAX_LOCK > 1) begin
          state    <= gnt1 ? OWN1 : OWN0;
          lock_cnt <= CW'(1);
        end
      end else if (!acc) begin
        state <= IDLE;
      end else begin
        lock_cnt <= lock_cnt + CW'(1);
        if (!sel_lock || lock_cnt == CW'(MAX_LOCK - 1)) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven directed checks of dmem_arbiter against a behavioural data memory
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_write, mem_read;
  logic [63:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [63:0] mem [0:127];
  int          total = 0;
  int          passed = 0;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[6:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[6:0]] <= mem_wdata;

  typedef struct {
    logic r0, w0, l0; logic [63:0] a0, d0;
    logic r1, w1, l1; logic [63:0] a1, d1;
    logic g0, g1, mw, mr;
    logic v0, v1, e0, e1; logic [63:0] rd0, rd1;
  } vec_t;

  localparam logic [63:0] DB = 64'hDEAD_BEEF;
  localparam logic [63:0] C0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] BIG = 64'h8000_0000_0000_0005;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic r0, w0, l0, input logic [63:0] a0, d0,
                       input logic r1, w1, l1, input logic [63:0] a1, d1);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
  endtask

  initial begin
    // r0 w0 l0 a0 d0 | r1 w1 l1 a1 d1 | g0 g1 mw mr | v0 v1 e0 e1 rd0 rd1
    // single-port write then read, then port 1 seeds addr 0
    tbl.push_back(vec_t'{1,1,0,5,DB,      0,0,0,0,0,          1,0,1,0, 1,0,0,0, 0,0});
    tbl.push_back(vec_t'{1,0,0,5,0,       0,0,0,0,0,          1,0,0,1, 1,0,0,0, DB,0});
    tbl.push_back(vec_t'{0,0,0,0,0,       1,1,0,0,C0,         0,1,1,0, 0,1,0,0, DB,0});
    // both ports read every cycle: strict alternation starting with port 0
    tbl.push_back(vec_t'{1,0,0,5,0,       1,0,0,0,0,          1,0,0,1, 1,0,0,0, DB,0});
    tbl.push_back(vec_t'{1,0,0,5,0,       1,0,0,0,0,          0,1,0,1, 0,1,0,0, DB,C0});
    tbl.push_back(vec_t'{1,0,0,5,0,       1,0,0,0,0,          1,0,0,1, 1,0,0,0, DB,C0});
    tbl.push_back(vec_t'{1,0,0,5,0,       1,0,0,0,0,          0,1,0,1, 0,1,0,0, DB,C0});
    tbl.push_back(vec_t'{1,0,0,5,0,       1,0,0,0,0,          1,0,0,1, 1,0,0,0, DB,C0});
    tbl.push_back(vec_t'{1,0,0,5,0,       1,0,0,0,0,          0,1,0,1, 0,1,0,0, DB,C0});
    // port 1 lock burst against continuous port 0 reads; lock ignored when not granted
    tbl.push_back(vec_t'{1,0,0,5,0,       1,1,1,10,64'hB00A,  1,0,0,1, 1,0,0,0, DB,C0});
    tbl.push_back(vec_t'{1,0,0,5,0,       1,1,1,10,64'hB00A,  0,1,1,0, 0,1,0,0, DB,0});
    tbl.push_back(vec_t'{1,0,0,5,0,       1,1,1,11,64'hB00B,  0,1,1,0, 0,1,0,0, DB,0});
    tbl.push_back(vec_t'{1,0,0,5,0,       1,1,1,12,64'hB00C,  0,1,1,0, 0,1,0,0, DB,0});
    tbl.push_back(vec_t'{1,0,0,5,0,       1,1,1,13,64'hB00D,  0,1,1,0, 0,1,0,0, DB,0});
    tbl.push_back(vec_t'{1,0,0,5,0,       1,1,0,14,64'hB00E,  1,0,0,1, 1,0,0,0, DB,0});
    tbl.push_back(vec_t'{1,0,0,5,0,       1,1,0,14,64'hB00E,  0,1,1,0, 0,1,0,0, DB,0});
    tbl.push_back(vec_t'{1,0,0,5,0,       1,1,0,15,64'hB00F,  1,0,0,1, 1,0,0,0, DB,0});
    tbl.push_back(vec_t'{1,0,0,5,0,       1,1,0,15,64'hB00F,  0,1,1,0, 0,1,0,0, DB,0});
    tbl.push_back(vec_t'{0,0,0,0,0,       1,0,0,13,0,         0,1,0,1, 0,1,0,0, DB,64'hB00D});
    // out-of-range write at DEPTH, aliasing check on addr 0, high-bit address
    tbl.push_back(vec_t'{1,1,0,128,64'hFFFF, 0,0,0,0,0,       1,0,0,0, 1,0,1,0, 0,64'hB00D});
    tbl.push_back(vec_t'{1,0,0,0,0,       0,0,0,0,0,          1,0,0,1, 1,0,0,0, C0,64'hB00D});
    tbl.push_back(vec_t'{0,0,0,0,0,       1,0,0,BIG,0,        0,1,0,0, 0,1,0,1, C0,0});
    // port 0 lock burst abandoned after two beats costs one idle cycle
    tbl.push_back(vec_t'{1,1,1,20,64'hC014, 1,0,0,5,0,        1,0,1,0, 1,0,0,0, 0,0});
    tbl.push_back(vec_t'{1,1,1,21,64'hC015, 1,0,0,5,0,        1,0,1,0, 1,0,0,0, 0,0});
    tbl.push_back(vec_t'{0,0,0,0,0,       1,0,0,5,0,          0,0,0,0, 0,0,0,0, 0,0});
    tbl.push_back(vec_t'{0,0,0,0,0,       1,0,0,5,0,          0,1,0,1, 0,1,0,0, 0,DB});
    tbl.push_back(vec_t'{0,0,0,0,0,       0,0,0,0,0,          0,0,0,0, 0,0,0,0, 0,DB});

    rst_n = 1'b0;
    drive(1,1,0,64'd3,64'h55, 1,1,0,64'd4,64'h66);
    repeat (2) @(posedge clk);
    #1;
    chk("rst gnt0", gnt0, 0);
    chk("rst gnt1", gnt1, 0);
    chk("rst mem_write", mem_write, 0);
    chk("rst mem_read", mem_read, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst rvalid0", rvalid0, 0);
    chk("rst rvalid1", rvalid1, 0);
    chk("rst err0", err0, 0);
    chk("rst rdata0", rdata0, 0);
    chk("rst rdata1", rdata1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].r0, tbl[i].w0, tbl[i].l0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].w1, tbl[i].l1, tbl[i].a1, tbl[i].d1);
      #1;
      chk($sformatf("row%0d gnt0", i), gnt0, tbl[i].g0);
      chk($sformatf("row%0d gnt1", i), gnt1, tbl[i].g1);
      chk($sformatf("row%0d mem_write", i), mem_write, tbl[i].mw);
      chk($sformatf("row%0d mem_read", i), mem_read, tbl[i].mr);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d rvalid0", i), rvalid0, tbl[i].v0);
      chk($sformatf("row%0d rvalid1", i), rvalid1, tbl[i].v1);
      chk($sformatf("row%0d err0", i), err0, tbl[i].e0);
      chk($sformatf("row%0d err1", i), err1, tbl[i].e1);
      chk($sformatf("row%0d rdata0", i), rdata0, tbl[i].rd0);
      chk($sformatf("row%0d rdata1", i), rdata1, tbl[i].rd1);
    end

    // asynchronous reset on the second beat of a port 1 lock burst
    @(negedge clk);
    drive(0,0,0,0,0, 1,1,1,64'd30,64'hD01E);
    @(posedge clk);
    @(negedge clk);
    drive(0,0,0,0,0, 1,1,1,64'd31,64'hD01F);
    #1;
    chk("burst beat2 gnt1", gnt1, 1);
    chk("burst beat2 mem_write", mem_write, 1);
    chk("burst beat1 rvalid1", rvalid1, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid-rst gnt1", gnt1, 0);
    chk("mid-rst gnt0", gnt0, 0);
    chk("mid-rst rvalid1", rvalid1, 0);
    chk("mid-rst mem_write", mem_write, 0);
    chk("mid-rst mem_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1,0,0,64'd5,0, 0,0,0,0,0);
    #1;
    chk("post-rst gnt0", gnt0, 1);
    chk("post-rst mem_read", mem_read, 1);
    @(posedge clk);
    #1;
    chk("post-rst rvalid0", rvalid0, 1);
    chk("post-rst rdata0", rdata0, DB);
    chk("post-rst rvalid1", rvalid1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
